icpu_program_loader: RTL and testbench

Streaming loader that writes a new program image into the Icpu (PicoBlaze) program memory's write port from an 8-bit byte stream (UART receiver or host bridge). Holds the Icpu in reset while the image is written. Releases it only after a length- and checksum-verified load. Sits directly upstream of the program memory and beside the Icpu reset input.

---
 rtl/icpu_loader_pkg.sv | 21 ++
 rtl/icpu_program_loader.sv | 175 +++++++++++++++++
 tb/tb_icpu_program_loader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/icpu_loader_pkg.sv
// Shared types and constants for the Icpu program loader and the program memory it feeds.
package icpu_loader_pkg;

  localparam logic [7:0]  HEADER_BYTE = 8'hA5;
  localparam int unsigned MAX_WORDS   = 1024;
  localparam int unsigned ADDR_WIDTH  = 10;
  localparam int unsigned INSTR_WIDTH = 18;
  localparam int unsigned COUNT_WIDTH = 11;
  localparam int unsigned TO_WIDTH    = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_W0,
    ST_W1,
    ST_W2,
    ST_CHECK
  } state_e;

endpackage

// File: rtl/icpu_program_loader.sv
// Byte-stream loader: parses A5/LEN/words/CHK frames, writes program memory and
// holds the Icpu in reset until a length- and checksum-verified image is loaded.
module icpu_program_loader
  import icpu_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   mem_write_enable,
  output logic [ADDR_WIDTH-1:0]  mem_write_address,
  output logic [INSTR_WIDTH-1:0] mem_write_data,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   load_ok,
  output logic                   load_error
);

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [7:0]               len_hi_q, len_hi_d;
  logic [COUNT_WIDTH-1:0]   remain_q, remain_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [7:0]               sum_q, sum_d;
  logic [1:0]               b0_q, b0_d;
  logic [7:0]               b1_q, b1_d;
  logic [TO_WIDTH-1:0]      to_q, to_d;
  logic                     we_q, we_d;
  logic [ADDR_WIDTH-1:0]    waddr_q, waddr_d;
  logic [INSTR_WIDTH-1:0]   wdata_q, wdata_d;
  logic                     cpu_reset_q, cpu_reset_d;
  logic                     busy_q, busy_d;
  logic                     load_ok_q, load_ok_d;
  logic                     load_error_q, load_error_d;
  logic [15:0]              len_word;
  logic                     timeout_hit;

  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    remain_d     = remain_q;
    addr_d       = addr_q;
    sum_d        = sum_q;
    b0_d         = b0_q;
    b1_d         = b1_q;
    to_d         = '0;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    cpu_reset_d  = cpu_reset_q;
    load_ok_d    = 1'b0;
    load_error_d = load_error_q;
    len_word     = {len_hi_q, rx_data};
    timeout_hit  = 1'b0;

    // Idle-gap counter; a strobe in the expiry cycle clears it instead of timing out
    if (state_q != ST_IDLE && !rx_valid) begin
      if (to_q == TO_LAST) timeout_hit = 1'b1;
      else                 to_d = to_q + TO_WIDTH'(1);
    end

    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == HEADER_BYTE) begin
            state_d      = ST_LEN_HI;
            cpu_reset_d  = 1'b1;
            load_error_d = 1'b0;
            sum_d        = '0;
            addr_d       = '0;
          end
        end
        ST_LEN_HI: begin
          len_hi_d = rx_data;
          sum_d    = sum_q + rx_data;
          state_d  = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          sum_d = sum_q + rx_data;
          if (len_word == 16'd0 || len_word > 16'(MAX_WORDS)) begin
            state_d      = ST_IDLE;
            load_error_d = 1'b1;
          end else begin
            remain_d = COUNT_WIDTH'(len_word);
            state_d  = ST_W0;
          end
        end
        ST_W0: begin
          b0_d    = rx_data[1:0];
          sum_d   = sum_q + rx_data;
          state_d = ST_W1;
        end
        ST_W1: begin
          b1_d    = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = ST_W2;
        end
        ST_W2: begin
          we_d     = 1'b1;
          waddr_d  = addr_q;
          wdata_d  = {b0_q, b1_q, rx_data};
          addr_d   = addr_q + ADDR_WIDTH'(1);
          remain_d = remain_q - COUNT_WIDTH'(1);
          sum_d    = sum_q + rx_data;
          state_d  = (remain_q == COUNT_WIDTH'(1)) ? ST_CHECK : ST_W0;
        end
        ST_CHECK: begin
          state_d = ST_IDLE;
          if (8'(sum_q + rx_data) == 8'd0) begin
            cpu_reset_d = 1'b0;
            load_ok_d   = 1'b1;
          end else begin
            load_error_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (timeout_hit) begin
      state_d      = ST_IDLE;
      load_error_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_hi_q     <= '0;
      remain_q     <= '0;
      addr_q       <= '0;
      sum_q        <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      to_q         <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      cpu_reset_q  <= 1'b0;
      busy_q       <= 1'b0;
      load_ok_q    <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      remain_q     <= remain_d;
      addr_q       <= addr_d;
      sum_q        <= sum_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      to_q         <= to_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      load_ok_q    <= load_ok_d;
      load_error_q <= load_error_d;
    end
  end

  assign mem_write_enable  = we_q;
  assign mem_write_address = waddr_q;
  assign mem_write_data    = wdata_q;
  assign cpu_reset         = cpu_reset_q;
  assign busy              = busy_q;
  assign load_ok           = load_ok_q;
  assign load_error        = load_error_q;

endmodule

// File: tb/tb_icpu_program_loader.sv
// Scoreboard bench for icpu_program_loader: stimulus pushes expected writes/events, a monitor pops them.
module tb_icpu_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        mem_write_enable;
  logic [9:0]  mem_write_address;
  logic [17:0] mem_write_data;
  logic        cpu_reset, busy, load_ok, load_error;

  int checks = 0;
  int failures = 0;

  logic [27:0] wr_q[$];
  int          ev_q[$];
  logic [27:0] exp_w;
  int          exp_e;
  logic        prev_err = 1'b0;
  logic [7:0]  wb[0:3071];

  icpu_program_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .cpu_reset(cpu_reset), .busy(busy),
    .load_ok(load_ok), .load_error(load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every write strobe and every ok/error event against the queues
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_write_enable) begin
        if (wr_q.size() == 0) check("unexpected_write", 32'({mem_write_address, mem_write_data}), 32'hFFFF_FFFF);
        else begin
          exp_w = wr_q.pop_front();
          check("write_addr_data", 32'({mem_write_address, mem_write_data}), 32'(exp_w));
        end
      end
      if (load_ok) begin
        exp_e = (ev_q.size() == 0) ? 0 : ev_q.pop_front();
        check("event_ok", 32'd1, 32'(exp_e));
        check("cpu_reset_on_ok", 32'(cpu_reset), 32'd0);
      end
      if (load_error && !prev_err) begin
        exp_e = (ev_q.size() == 0) ? 0 : ev_q.pop_front();
        check("event_error", 32'd2, 32'(exp_e));
        check("cpu_reset_on_error", 32'(cpu_reset), 32'd1);
      end
    end
    prev_err = load_error;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // Sends A5/LEN/words(from wb)/CHK; expectations come from the checksum rule
  task automatic send_frame(input logic [15:0] n, input logic bad_chk);
    logic [7:0] s;
    logic [7:0] chk;
    s = n[15:8] + n[7:0];
    if (n == 16'd0 || n > 16'd1024) begin
      ev_q.push_back(2);
      send_byte(8'hA5); send_byte(n[15:8]); send_byte(n[7:0]);
      idle(3);
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      wr_q.push_back({10'(i), wb[3*i][1:0], wb[3*i+1], wb[3*i+2]});
      s = s + wb[3*i] + wb[3*i+1] + wb[3*i+2];
    end
    chk = 8'h00 - s + (bad_chk ? 8'h01 : 8'h00);
    ev_q.push_back(bad_chk ? 2 : 1);
    send_byte(8'hA5); send_byte(n[15:8]); send_byte(n[7:0]);
    for (int i = 0; i < 3 * int'(n); i++) send_byte(wb[i]);
    send_byte(chk);
    idle(3);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outputs", 32'({mem_write_enable, load_ok, load_error}), 32'd0);
    check("rst_addr_data", 32'({mem_write_address, mem_write_data}), 32'd0);
    reset = 1'b0;

    // Garbage before header is ignored
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    idle(1);
    check("garbage_busy", 32'(busy), 32'd0);
    check("garbage_cpu_reset", 32'(cpu_reset), 32'd0);

    // Good 2-word frame (checksum 0x3D)
    wb[0] = 8'h03; wb[1] = 8'h12; wb[2] = 8'h34; wb[3] = 8'h00; wb[4] = 8'hAB; wb[5] = 8'hCD;
    send_frame(16'd2, 1'b0);
    check("good_cpu_reset", 32'(cpu_reset), 32'd0);
    check("good_hold_addr", 32'(mem_write_address), 32'd1);
    check("good_hold_data", 32'(mem_write_data), 32'h0ABCD);

    // Bad checksum, then good frame clears the error
    send_frame(16'd2, 1'b1);
    check("badchk_error", 32'(load_error), 32'd1);
    check("badchk_cpu_reset", 32'(cpu_reset), 32'd1);
    send_frame(16'd2, 1'b0);
    check("recover_error", 32'(load_error), 32'd0);
    check("recover_cpu_reset", 32'(cpu_reset), 32'd0);

    // Length bounds
    send_frame(16'h0000, 1'b0);
    check("len0_error", 32'(load_error), 32'd1);
    send_frame(16'h0401, 1'b0);
    check("len1025_error", 32'(load_error), 32'd1);
    check("len1025_busy", 32'(busy), 32'd0);

    // Data byte A5 inside a frame is data
    wb[0] = 8'hA5; wb[1] = 8'hA5; wb[2] = 8'hA5;
    send_frame(16'd1, 1'b0);
    check("a5_data", 32'(mem_write_data), 32'h1A5A5);

    // Timeout after W1 of word 0: error at the 16th idle cycle, no write
    ev_q.push_back(2);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h03); send_byte(8'h12);
    idle(16);
    check("to_before_error", 32'(load_error), 32'd0);
    check("to_before_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("to_expired_error", 32'(load_error), 32'd1);
    check("to_expired_busy", 32'(busy), 32'd0);
    check("to_cpu_reset", 32'(cpu_reset), 32'd1);
    idle(2);

    // Byte in the expiry cycle wins
    wr_q.push_back({10'd0, 18'h31234});
    ev_q.push_back(1);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h03); send_byte(8'h12);
    idle(15);
    send_byte(8'h34);
    send_byte(8'hB6);
    idle(3);
    check("to_race_ok", 32'({load_error, cpu_reset}), 32'd0);

    // Reset during W1
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h03);
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ctrl", 32'({cpu_reset, busy, load_ok, load_error, mem_write_enable}), 32'd0);
    check("midrst_addr_data", 32'({mem_write_address, mem_write_data}), 32'd0);
    reset = 1'b0;
    wb[0] = 8'hFE; wb[1] = 8'h55; wb[2] = 8'h66;
    send_frame(16'd1, 1'b0);
    check("midrst_reload", 32'(mem_write_data), 32'h25566);

    // Full 1024-word image
    for (int i = 0; i < 1024; i++) begin
      wb[3*i]   = 8'hFC | 8'(i >> 8);
      wb[3*i+1] = 8'(i);
      wb[3*i+2] = ~8'(i);
    end
    send_frame(16'h0400, 1'b0);
    check("full_last_addr", 32'(mem_write_address), 32'd1023);
    check("full_cpu_reset", 32'(cpu_reset), 32'd0);

    idle(5);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("ev_q_drained", 32'(ev_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
